jtag_dtm: RTL and testbench
===========================

Name: jtag_dtm

Overview:
RISC-V Debug Transport Module that sits directly downstream of the JTAG TAP's custom-register interface. It implements the DTMCS register (custom index 0, IR 0x10) and the DMI register (custom index 1, IR 0x11). DMI scans are turned into valid/ready request transactions toward the Debug Module, and DM responses are returned into the next DMI capture. All logic runs in one clock domain, the TAP clock. Any crossing to the core clock is handled downstream of dmi_*.

Parameters:
DMI_ABITS, 7, DMI address width; reported in dtmcs.abits.
DR_WIDTH, 41, TAP data-register width; must be >= DMI_ABITS+34; unused upper bits read 0.
IDLE_HINT, 3'd1, value reported in dtmcs.idle[14:12].

Ports:
clk_i  in  1  clock (TAP tck)
rst_i  in  1  synchronous active-high reset
cust_rg_addr_i  in  1  custom register index from TAP (0=DTMCS, 1=DMI)
cust_rg_val_i  in  1  custom register selected by IR
cust_rg_dat_i  in  DR_WIDTH  shifted-in value from TAP, valid with we
cust_rg_dat_o  out  DR_WIDTH  capture value to TAP
cust_rg_dat_re_i  in  1  TAP in Capture-DR on a custom register
cust_rg_dat_we_i  in  1  TAP in Update-DR on a custom register
dmi_req_valid_o  out  1  DMI request valid
dmi_req_ready_i  in  1  DM accepts request
dmi_req_addr_o  out  DMI_ABITS  request address
dmi_req_data_o  out  32  request write data
dmi_req_op_o  out  2  1=read, 2=write
dmi_resp_valid_i  in  1  DM response valid
dmi_resp_ready_o  out  1  DTM accepts response
dmi_resp_data_i  in  32  response data
dmi_resp_op_i  in  2  0=ok, 2=failed, 3=busy

Behaviour:
- Interface: one clock, clk_i; synchronous active-high reset rst_i.
- Reset values:
  - FSM = IDLE; sticky_err = 0.
  - addr_q, data_q, resp_data_q = 0.
  - dmi_req_valid_o = 0; dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o = 0.
  - dmi_resp_ready_o = 1 (IDLE).
- cust_rg_dat_o is purely combinational from registered state. The TAP samples it in the same cycle re is high, so zero latency is required.
  - index 0 (DTMCS): [3:0]=1, [9:4]=DMI_ABITS, [11:10]=sticky_err, [14:12]=IDLE_HINT, all else 0.
  - index 1 (DMI): [1:0]=op_rd, [33:2]=resp_data_q, [33+DMI_ABITS:34]=addr_q, upper bits 0.
  - op_rd = 3 if FSM != IDLE; else sticky_err.
  - cust_rg_val_i=0: output all zeros.
- Capture in a non-IDLE state sets sticky_err=3 if it is currently 0. re is ignored otherwise.
- FSM states:
  - IDLE: dmi_resp_ready_o=1.
  - REQ: dmi_req_valid_o=1; outputs held stable until dmi_req_ready_i.
  - WAIT: dmi_resp_ready_o=1.
- Transitions and actions on DMI Update (we & val & addr==1), decoded from cust_rg_dat_i:
  - In IDLE with sticky_err==0 and op in {1,2}: latch addr/data/op to the request outputs and addr_q; go to REQ next cycle.
  - In IDLE with op 0 or 3, or sticky_err!=0: no request; registers unchanged.
  - In REQ or WAIT: sticky_err=3 if 0; request in flight unaffected.
- REQ -> WAIT on valid&ready in the same cycle; dmi_req_valid_o drops the next cycle.
- WAIT -> IDLE on resp_valid:
  - resp_data_q <= dmi_resp_data_i.
  - If sticky_err==0: sticky_err <= 2 for resp op 2, 3 for resp op 3.
  - Resp op 1 is treated as 2.
- Responses arriving in IDLE or REQ are accepted and discarded (no state change).
- DTMCS Update (we & val & addr==0):
  - bit16 dmireset clears sticky_err.
  - bit17 dmihardreset clears sticky_err, forces FSM to IDLE and drops dmi_req_valid_o next cycle (abort). A late response is then discarded per the rule above.
  - Other bits are ignored.
- Simultaneous events:
  - A response completing in the same cycle as a DTMCS dmireset: the reset wins and sticky_err ends 0.
  - rst_i overrides everything, including a pending handshake. valid drops the next cycle without waiting for ready.
- we and re are never both high (different TAP states); no priority is defined between them.

Test Plan:
- Capture DTMCS after reset -> cust_rg_dat_o = 0x0000_1071 (version 1, abits 7, idle 1, dmistat 0).
- DMI update addr=0x10, data=0xDEADBEEF, op=2; DM ready after 2 cycles; response ok -> req valid 2 cycles with op 2; next DMI capture op=0, addr field 0x10.
- DMI read addr=0x11, response data=0x12345678 op 0 -> capture = {0x11, 0x12345678, 2'b00}.
- DMI update issued while in WAIT -> no second request; capture op=3; DTMCS dmistat=3; further updates ignored until a DTMCS write with bit16=1, after which dmistat=0 and a new read is issued.
- Response op 2 -> dmistat=2; a later response op 3 does not overwrite it (stays 2).
- dmihardreset written while REQ held with ready=0 -> valid low the next cycle, FSM IDLE; a stray response 3 cycles later is accepted and discarded, resp_data_q unchanged; rst_i mid-REQ -> all outputs at reset values.

Source files
------------

// File: rtl/jtag_dtm.sv
// rtl/jtag_dtm.sv - RISC-V debug transport module (DTMCS and DMI registers behind a JTAG TAP)
module jtag_dtm #(
   parameter int         DMI_ABITS = 7,
   parameter int         DR_WIDTH  = 41,
   parameter logic [2:0] IDLE_HINT = 3'd1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cust_rg_addr_i,
   input  logic                 cust_rg_val_i,
   input  logic [DR_WIDTH-1:0]  cust_rg_dat_i,
   output logic [DR_WIDTH-1:0]  cust_rg_dat_o,
   input  logic                 cust_rg_dat_re_i,
   input  logic                 cust_rg_dat_we_i,
   output logic                 dmi_req_valid_o,
   input  logic                 dmi_req_ready_i,
   output logic [DMI_ABITS-1:0] dmi_req_addr_o,
   output logic [31:0]          dmi_req_data_o,
   output logic [1:0]           dmi_req_op_o,
   input  logic                 dmi_resp_valid_i,
   output logic                 dmi_resp_ready_o,
   input  logic [31:0]          dmi_resp_data_i,
   input  logic [1:0]           dmi_resp_op_i
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t                r_state;
   logic [1:0]            r_sticky_err;
   logic [DMI_ABITS-1:0]  r_addr_q;
   logic [31:0]           r_resp_data_q;
   logic                  r_req_valid;
   logic [DMI_ABITS-1:0]  r_req_addr;
   logic [31:0]           r_req_data;
   logic [1:0]            r_req_op;
   logic                  r_resp_ready;

   logic                  w_dmi_upd;
   logic                  w_dtmcs_upd;
   logic                  w_dmi_cap;
   logic [1:0]            w_upd_op;
   logic [31:0]           w_upd_data;
   logic [DMI_ABITS-1:0]  w_upd_addr;
   logic [1:0]            w_op_rd;
   logic                  w_upd_is_req;

   assign w_dmi_upd    = cust_rg_dat_we_i & cust_rg_val_i & cust_rg_addr_i;
   assign w_dtmcs_upd  = cust_rg_dat_we_i & cust_rg_val_i & ~cust_rg_addr_i;
   assign w_dmi_cap    = cust_rg_dat_re_i & cust_rg_val_i & cust_rg_addr_i;
   assign w_upd_op     = cust_rg_dat_i[1:0];
   assign w_upd_data   = cust_rg_dat_i[33:2];
   assign w_upd_addr   = cust_rg_dat_i[33+DMI_ABITS:34];
   assign w_upd_is_req = (w_upd_op == 2'd1) || (w_upd_op == 2'd2);

   // A transaction in flight always reads back as busy; otherwise the sticky status
   assign w_op_rd = (r_state != ST_IDLE) ? 2'd3 : r_sticky_err;

   assign dmi_req_valid_o  = r_req_valid;
   assign dmi_req_addr_o   = r_req_addr;
   assign dmi_req_data_o   = r_req_data;
   assign dmi_req_op_o     = r_req_op;
   assign dmi_resp_ready_o = r_resp_ready;

   // Upper scan bits beyond the DMI fields carry no meaning
   generate
      if (DR_WIDTH > DMI_ABITS + 34) begin : g_unused_hi
         logic w_unused_hi;
         assign w_unused_hi = ^cust_rg_dat_i[DR_WIDTH-1:DMI_ABITS+34];
      end
   endgenerate

   // Capture value: zero-latency mux of registered state, sampled by the TAP in Capture-DR
   always_comb begin
      cust_rg_dat_o = '0;
      if (cust_rg_val_i) begin
         if (!cust_rg_addr_i) begin
            cust_rg_dat_o[3:0]   = 4'd1;
            cust_rg_dat_o[9:4]   = 6'(DMI_ABITS);
            cust_rg_dat_o[11:10] = r_sticky_err;
            cust_rg_dat_o[14:12] = IDLE_HINT;
         end else begin
            cust_rg_dat_o[1:0]             = w_op_rd;
            cust_rg_dat_o[33:2]            = r_resp_data_q;
            cust_rg_dat_o[33+DMI_ABITS:34] = r_addr_q;
         end
      end
   end

   // DMI transaction FSM with sticky error tracking; DTMCS resets are applied last so they win
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state       <= ST_IDLE;
         r_sticky_err  <= 2'd0;
         r_addr_q      <= '0;
         r_resp_data_q <= '0;
         r_req_valid   <= 1'b0;
         r_req_addr    <= '0;
         r_req_data    <= '0;
         r_req_op      <= 2'd0;
         r_resp_ready  <= 1'b1;
      end else begin
         // The DTM never back-pressures responses; stray ones are simply dropped
         r_resp_ready <= 1'b1;

         if (w_dmi_cap && (r_state != ST_IDLE) && (r_sticky_err == 2'd0)) begin
            r_sticky_err <= 2'd3;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_dmi_upd && (r_sticky_err == 2'd0) && w_upd_is_req) begin
                  r_req_addr  <= w_upd_addr;
                  r_req_data  <= w_upd_data;
                  r_req_op    <= w_upd_op;
                  r_addr_q    <= w_upd_addr;
                  r_req_valid <= 1'b1;
                  r_state     <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (w_dmi_upd && (r_sticky_err == 2'd0)) begin
                  r_sticky_err <= 2'd3;
               end
               if (r_req_valid && dmi_req_ready_i) begin
                  r_req_valid <= 1'b0;
                  r_state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (w_dmi_upd && (r_sticky_err == 2'd0)) begin
                  r_sticky_err <= 2'd3;
               end
               if (dmi_resp_valid_i) begin
                  r_resp_data_q <= dmi_resp_data_i;
                  r_state       <= ST_IDLE;
                  if (r_sticky_err == 2'd0) begin
                     if (dmi_resp_op_i == 2'd3) begin
                        r_sticky_err <= 2'd3;
                     end else if (dmi_resp_op_i != 2'd0) begin
                        r_sticky_err <= 2'd2;
                     end
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase

         if (w_dtmcs_upd && (cust_rg_dat_i[16] || cust_rg_dat_i[17])) begin
            r_sticky_err <= 2'd0;
         end
         if (w_dtmcs_upd && cust_rg_dat_i[17]) begin
            r_state     <= ST_IDLE;
            r_req_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_jtag_dtm.sv
// tb/tb_jtag_dtm.sv - directed table and sequence checks for jtag_dtm
module tb_jtag_dtm;
   localparam int A = 7;
   localparam int W = 41;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          cust_rg_addr_i;
   logic          cust_rg_val_i;
   logic [W-1:0]  cust_rg_dat_i;
   logic [W-1:0]  cust_rg_dat_o;
   logic          cust_rg_dat_re_i;
   logic          cust_rg_dat_we_i;
   logic          dmi_req_valid_o;
   logic          dmi_req_ready_i;
   logic [A-1:0]  dmi_req_addr_o;
   logic [31:0]   dmi_req_data_o;
   logic [1:0]    dmi_req_op_o;
   logic          dmi_resp_valid_i;
   logic          dmi_resp_ready_o;
   logic [31:0]   dmi_resp_data_i;
   logic [1:0]    dmi_resp_op_i;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   jtag_dtm #(.DMI_ABITS(A), .DR_WIDTH(W), .IDLE_HINT(3'd1)) dut (
      .clk_i            (clk),
      .rst_i            (rst_i),
      .cust_rg_addr_i   (cust_rg_addr_i),
      .cust_rg_val_i    (cust_rg_val_i),
      .cust_rg_dat_i    (cust_rg_dat_i),
      .cust_rg_dat_o    (cust_rg_dat_o),
      .cust_rg_dat_re_i (cust_rg_dat_re_i),
      .cust_rg_dat_we_i (cust_rg_dat_we_i),
      .dmi_req_valid_o  (dmi_req_valid_o),
      .dmi_req_ready_i  (dmi_req_ready_i),
      .dmi_req_addr_o   (dmi_req_addr_o),
      .dmi_req_data_o   (dmi_req_data_o),
      .dmi_req_op_o     (dmi_req_op_o),
      .dmi_resp_valid_i (dmi_resp_valid_i),
      .dmi_resp_ready_o (dmi_resp_ready_o),
      .dmi_resp_data_i  (dmi_resp_data_i),
      .dmi_resp_op_i    (dmi_resp_op_i)
   );

   typedef struct {
      logic          val;
      logic          adr;
      logic          re;
      logic          we;
      logic [W-1:0]  din;
      logic          rdy;
      logic          rv;
      logic [31:0]   rdata;
      logic [1:0]    rop;
      logic [W-1:0]  e_dout;
      logic          e_valid;
      logic [1:0]    e_op;
      logic [A-1:0]  e_addr;
      logic [31:0]   e_data;
   } vec_t;

   vec_t tbl [12];

   localparam logic [W-1:0] DTMCS_OK   = 41'h1071;
   localparam logic [W-1:0] DTMCS_BUSY = 41'h1C71;
   localparam logic [W-1:0] DTMCS_FAIL = 41'h1871;
   localparam logic [W-1:0] RST_BIT    = 41'h10000;
   localparam logic [W-1:0] HRST_BIT   = 41'h20000;

   function automatic logic [W-1:0] dmi_w(input logic [A-1:0] a, input logic [31:0] d, input logic [1:0] op);
      return W'({a, d, op});
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Inputs change at the falling edge; outputs are observed 1ns later
   task automatic drive(input logic val, input logic adr, input logic re, input logic we,
                        input logic [W-1:0] din, input logic rdy, input logic rv,
                        input logic [31:0] rdata, input logic [1:0] rop);
      @(negedge clk);
      cust_rg_val_i    = val;
      cust_rg_addr_i   = adr;
      cust_rg_dat_re_i = re;
      cust_rg_dat_we_i = we;
      cust_rg_dat_i    = din;
      dmi_req_ready_i  = rdy;
      dmi_resp_valid_i = rv;
      dmi_resp_data_i  = rdata;
      dmi_resp_op_i    = rop;
      #1;
   endtask

   task automatic view_dmi();
      drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 32'h0, 2'd0);
   endtask

   task automatic view_dtmcs();
      drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 32'h0, 2'd0);
   endtask

   task automatic dmi_upd(input logic [A-1:0] a, input logic [31:0] d, input logic [1:0] op);
      drive(1'b1, 1'b1, 1'b0, 1'b1, dmi_w(a, d, op), 1'b0, 1'b0, 32'h0, 2'd0);
   endtask

   initial begin
      rst_i = 1'b1;
      cust_rg_val_i = 1'b0; cust_rg_addr_i = 1'b0; cust_rg_dat_re_i = 1'b0; cust_rg_dat_we_i = 1'b0;
      cust_rg_dat_i = '0; dmi_req_ready_i = 1'b0; dmi_resp_valid_i = 1'b0;
      dmi_resp_data_i = 32'h0; dmi_resp_op_i = 2'd0;

      //         val   adr   re    we    din                                   rdy   rv    rdata          rop    e_dout                                e_valid e_op  e_addr e_data
      tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, '0,                                  1'b0, 1'b0, 32'h0,         2'd0, DTMCS_OK,                            1'b0, 2'd0, 7'h00, 32'h0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, dmi_w(7'h10, 32'hDEADBEEF, 2'd2), 1'b0, 1'b0, 32'h0,         2'd0, '0,                                  1'b0, 2'd0, 7'h00, 32'h0};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, '0,                                  1'b0, 1'b0, 32'h0,         2'd0, '0,                                  1'b1, 2'd2, 7'h10, 32'hDEADBEEF};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, '0,                                  1'b1, 1'b0, 32'h0,         2'd0, '0,                                  1'b1, 2'd2, 7'h10, 32'hDEADBEEF};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, '0,                                  1'b0, 1'b0, 32'h0,         2'd0, dmi_w(7'h10, 32'h0, 2'd3),           1'b0, 2'd0, 7'h00, 32'h0};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, '0,                                  1'b0, 1'b1, 32'h0,         2'd0, dmi_w(7'h10, 32'h0, 2'd3),           1'b0, 2'd0, 7'h00, 32'h0};
      tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, '0,                                  1'b0, 1'b0, 32'h0,         2'd0, dmi_w(7'h10, 32'h0, 2'd0),           1'b0, 2'd0, 7'h00, 32'h0};
      tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, dmi_w(7'h11, 32'h0, 2'd1),        1'b0, 1'b0, 32'h0,         2'd0, dmi_w(7'h10, 32'h0, 2'd0),           1'b0, 2'd0, 7'h00, 32'h0};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, '0,                                  1'b1, 1'b0, 32'h0,         2'd0, dmi_w(7'h11, 32'h0, 2'd3),           1'b1, 2'd1, 7'h11, 32'h0};
      tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, '0,                                  1'b0, 1'b1, 32'h12345678,  2'd0, dmi_w(7'h11, 32'h0, 2'd3),           1'b0, 2'd0, 7'h00, 32'h0};
      tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, '0,                                  1'b0, 1'b0, 32'h0,         2'd0, dmi_w(7'h11, 32'h12345678, 2'd0),    1'b0, 2'd0, 7'h00, 32'h0};
      tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, '0,                                  1'b0, 1'b0, 32'h0,         2'd0, DTMCS_OK,                            1'b0, 2'd0, 7'h00, 32'h0};

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_req_valid", W'(dmi_req_valid_o), W'(1'b0));
      chk("rst_resp_ready", W'(dmi_resp_ready_o), W'(1'b1));
      chk("rst_req_fields", W'({dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o}), '0);
      rst_i = 1'b0;

      // Write then read transaction, one vector per clock
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].val, tbl[i].adr, tbl[i].re, tbl[i].we, tbl[i].din,
               tbl[i].rdy, tbl[i].rv, tbl[i].rdata, tbl[i].rop);
         chk($sformatf("v%0d_dout", i), cust_rg_dat_o, tbl[i].e_dout);
         chk($sformatf("v%0d_valid", i), W'(dmi_req_valid_o), W'(tbl[i].e_valid));
         chk($sformatf("v%0d_resp_ready", i), W'(dmi_resp_ready_o), W'(1'b1));
         if (tbl[i].e_valid) begin
            chk($sformatf("v%0d_op", i), W'(dmi_req_op_o), W'(tbl[i].e_op));
            chk($sformatf("v%0d_addr", i), W'(dmi_req_addr_o), W'(tbl[i].e_addr));
            chk($sformatf("v%0d_data", i), W'(dmi_req_data_o), W'(tbl[i].e_data));
         end
      end

      // Update while busy: no second request, sticky busy until dmireset
      dmi_upd(7'h05, 32'h0, 2'd1);
      drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 32'h0, 2'd0);
      chk("busy_req_valid", W'(dmi_req_valid_o), W'(1'b1));
      chk("busy_req_addr", W'(dmi_req_addr_o), W'(7'h05));
      dmi_upd(7'h06, 32'h0000AAAA, 2'd2);
      view_dmi();
      chk("busy_no_second_req", W'(dmi_req_valid_o), W'(1'b0));
      chk("busy_dmi_capture", cust_rg_dat_o, dmi_w(7'h05, 32'h12345678, 2'd3));
      view_dtmcs();
      chk("busy_dtmcs", cust_rg_dat_o, DTMCS_BUSY);
      drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, 32'h0000BEEF, 2'd2);
      view_dtmcs();
      chk("sticky_keeps_busy", cust_rg_dat_o, DTMCS_BUSY);
      dmi_upd(7'h07, 32'h0, 2'd1);
      view_dmi();
      chk("sticky_blocks_req", W'(dmi_req_valid_o), W'(1'b0));
      chk("sticky_dmi_capture", cust_rg_dat_o, dmi_w(7'h05, 32'h0000BEEF, 2'd3));
      drive(1'b1, 1'b0, 1'b0, 1'b1, RST_BIT, 1'b0, 1'b0, 32'h0, 2'd0);
      view_dtmcs();
      chk("dmireset_clears", cust_rg_dat_o, DTMCS_OK);

      // New read after dmireset, failed response, then a stray busy response
      dmi_upd(7'h07, 32'h0, 2'd1);
      drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 32'h0, 2'd0);
      chk("reissue_valid", W'(dmi_req_valid_o), W'(1'b1));
      chk("reissue_addr", W'(dmi_req_addr_o), W'(7'h07));
      drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, 32'h00000BEE, 2'd2);
      view_dtmcs();
      chk("resp_failed_dmistat", cust_rg_dat_o, DTMCS_FAIL);
      drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, 32'h0000BAD0, 2'd3);
      view_dtmcs();
      chk("failed_not_overwritten", cust_rg_dat_o, DTMCS_FAIL);
      view_dmi();
      chk("stray_idle_discarded", cust_rg_dat_o, dmi_w(7'h07, 32'h00000BEE, 2'd2));
      drive(1'b1, 1'b0, 1'b0, 1'b1, RST_BIT, 1'b0, 1'b0, 32'h0, 2'd0);

      // dmihardreset aborts a request held without ready
      dmi_upd(7'h20, 32'hCAFEF00D, 2'd2);
      view_dmi();
      chk("hold_valid", W'(dmi_req_valid_o), W'(1'b1));
      chk("hold_data", W'(dmi_req_data_o), W'(32'hCAFEF00D));
      drive(1'b1, 1'b0, 1'b0, 1'b1, HRST_BIT, 1'b0, 1'b0, 32'h0, 2'd0);
      chk("hold_still_valid", W'(dmi_req_valid_o), W'(1'b1));
      chk("hold_still_addr", W'(dmi_req_addr_o), W'(7'h20));
      view_dmi();
      chk("hardreset_valid_low", W'(dmi_req_valid_o), W'(1'b0));
      chk("hardreset_idle_capture", cust_rg_dat_o, dmi_w(7'h20, 32'h00000BEE, 2'd0));
      view_dmi();
      view_dmi();
      drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, 32'h00000BAD, 2'd3);
      view_dmi();
      chk("late_resp_discarded", cust_rg_dat_o, dmi_w(7'h20, 32'h00000BEE, 2'd0));
      view_dtmcs();
      chk("late_resp_dmistat", cust_rg_dat_o, DTMCS_OK);

      // Failed response completing together with dmireset: reset wins
      dmi_upd(7'h30, 32'h0, 2'd1);
      drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 32'h0, 2'd0);
      drive(1'b1, 1'b0, 1'b0, 1'b1, RST_BIT, 1'b0, 1'b1, 32'h0000600D, 2'd2);
      view_dtmcs();
      chk("simul_reset_wins", cust_rg_dat_o, DTMCS_OK);
      view_dmi();
      chk("simul_resp_data", cust_rg_dat_o, dmi_w(7'h30, 32'h0000600D, 2'd0));

      // Synchronous reset in the middle of a request, with ready arriving at the same edge
      dmi_upd(7'h3F, 32'h11112222, 2'd2);
      view_dmi();
      chk("pre_rst_valid", W'(dmi_req_valid_o), W'(1'b1));
      rst_i = 1'b1;
      dmi_req_ready_i = 1'b1;
      view_dmi();
      rst_i = 1'b0;
      chk("midrst_valid", W'(dmi_req_valid_o), W'(1'b0));
      chk("midrst_req_fields", W'({dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o}), '0);
      chk("midrst_resp_ready", W'(dmi_resp_ready_o), W'(1'b1));
      chk("midrst_dmi_capture", cust_rg_dat_o, '0);
      view_dtmcs();
      chk("midrst_dtmcs", cust_rg_dat_o, DTMCS_OK);
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 32'h0, 2'd0);
      chk("unselected_zero", cust_rg_dat_o, '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
